// File: rtl/clkdiv_seq_ctrl_pkg.sv
// clkdiv_ctrl_pkg: sequencer states, default timing and width helpers for the CLKDIV sequencer.
package clkdiv_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE, WAIT_LOCK, HOLD_RST, SETTLE, READY, CALIB_PULSE, CALIB_GAP, FAIL
    } state_e;
    typedef struct packed {
        logic resetn;
        logic calib;
        logic ready;
        logic busy;
        logic fail;
    } outs_t;
    localparam int LOCK_FILT_DEF       = 8;
    localparam int RST_HOLD_CYC_DEF    = 16;
    localparam int SETTLE_CYC_DEF      = 64;
    localparam int CALIB_PULSE_CYC_DEF = 2;
    localparam int CALIB_GAP_CYC_DEF   = 8;
    localparam int MAX_CALIB_DEF       = 4;
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/clkdiv_seq_ctrl_if.sv
// clkdiv_seq_ctrl_if: control/status bundle between the CLKDIV sequencer and its environment.
interface clkdiv_seq_ctrl_if
    import clkdiv_ctrl_pkg::*;
#(
    parameter int CNT_W = cnt_width(MAX_CALIB_DEF)
);
    logic             enable_i;
    logic             pll_lock_i;
    logic             calib_req_i;
    logic             align_ok_i;
    logic             clkdiv_resetn_o;
    logic             clkdiv_calib_o;
    logic             ready_o;
    logic             busy_o;
    logic [CNT_W-1:0] calib_cnt_o;
    logic             fail_o;
    modport master (
        output enable_i, pll_lock_i, calib_req_i, align_ok_i,
        input  clkdiv_resetn_o, clkdiv_calib_o, ready_o, busy_o, calib_cnt_o, fail_o
    );
    modport slave (
        input  enable_i, pll_lock_i, calib_req_i, align_ok_i,
        output clkdiv_resetn_o, clkdiv_calib_o, ready_o, busy_o, calib_cnt_o, fail_o
    );
endinterface

// File: rtl/clkdiv_seq_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) sync_q <= '0;
        else sync_q <= {sync_q[0], d_i};
    assign q_o = sync_q[1];
endmodule

// File: rtl/clkdiv_seq_ctrl.sv
// clkdiv_seq_ctrl: bring-up and CALIB sequencer for a Gowin CLKDIV macro.
// Holds the divider in reset until PLL lock is filtered, lets it settle, then serves phase-rotation requests.
module clkdiv_seq_ctrl
    import clkdiv_ctrl_pkg::*;
#(
    parameter int LOCK_FILT       = LOCK_FILT_DEF,
    parameter int RST_HOLD_CYC    = RST_HOLD_CYC_DEF,
    parameter int SETTLE_CYC      = SETTLE_CYC_DEF,
    parameter int CALIB_PULSE_CYC = CALIB_PULSE_CYC_DEF,
    parameter int CALIB_GAP_CYC   = CALIB_GAP_CYC_DEF,
    parameter int MAX_CALIB       = MAX_CALIB_DEF
) (
    input logic              clk,
    input logic              rst,
    clkdiv_seq_ctrl_if.slave ctl
);
    localparam int LW = cnt_width(LOCK_FILT);
    localparam int TW = cnt_width(max2(max2(RST_HOLD_CYC, SETTLE_CYC), max2(CALIB_PULSE_CYC, CALIB_GAP_CYC)));
    localparam int CW = cnt_width(MAX_CALIB);
    localparam logic [TW-1:0] HOLD_LD   = TW'(RST_HOLD_CYC - 1);
    localparam logic [TW-1:0] SETTLE_LD = TW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD  = TW'(CALIB_PULSE_CYC - 1);
    localparam logic [TW-1:0] GAP_LD    = TW'(CALIB_GAP_CYC - 1);

    state_e        state_q, state_d;
    logic [LW-1:0] filt_q, filt_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_eff;
    outs_t         outs_q, outs_d;
    logic          lock_s, lock_ok, tmr_done, lock_lost;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ctl.pll_lock_i),
        .q_o (lock_s)
    );

    assign lock_ok   = filt_q == LW'(LOCK_FILT);
    assign filt_d    = !lock_s ? '0 : lock_ok ? filt_q : filt_q + LW'(1);
    assign tmr_done  = tmr_q == '0;
    assign lock_lost = !lock_s && (state_q inside {HOLD_RST, SETTLE, READY, CALIB_PULSE, CALIB_GAP, FAIL});
    // a simultaneous align_ok clears the attempt count before the request is judged
    assign cnt_eff   = ctl.align_ok_i ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_done ? tmr_q : tmr_q - TW'(1);
        cnt_d   = cnt_q;
        case (state_q)
            IDLE:        state_d = WAIT_LOCK;
            WAIT_LOCK:   if (lock_ok) begin
                             state_d = HOLD_RST;
                             tmr_d   = HOLD_LD;
                         end
            HOLD_RST:    if (tmr_done) begin
                             state_d = SETTLE;
                             tmr_d   = SETTLE_LD;
                         end
            SETTLE:      if (tmr_done) state_d = READY;
            READY: begin
                cnt_d = cnt_eff;
                if (ctl.calib_req_i && cnt_eff < CW'(MAX_CALIB)) begin
                    cnt_d   = cnt_eff + CW'(1);
                    state_d = CALIB_PULSE;
                    tmr_d   = PULSE_LD;
                end else if (ctl.calib_req_i) begin
                    state_d = FAIL;
                end
            end
            CALIB_PULSE: if (tmr_done) begin
                             state_d = CALIB_GAP;
                             tmr_d   = GAP_LD;
                         end
            CALIB_GAP:   if (tmr_done) state_d = READY;
            default:     state_d = state_q;
        endcase
        // enable low outranks lock loss; both abort whatever is in flight
        if (!ctl.enable_i || lock_lost) begin
            state_d = ctl.enable_i ? WAIT_LOCK : IDLE;
            tmr_d   = '0;
            cnt_d   = '0;
        end
    end

    assign outs_d = '{
        resetn: state_d inside {SETTLE, READY, CALIB_PULSE, CALIB_GAP, FAIL},
        calib:  state_d == CALIB_PULSE,
        ready:  state_d == READY,
        busy:   state_d inside {CALIB_PULSE, CALIB_GAP},
        fail:   state_d == FAIL
    };

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            filt_q  <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            outs_q  <= '0;
        end else begin
            state_q <= state_d;
            filt_q  <= filt_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            outs_q  <= outs_d;
        end

    assign ctl.clkdiv_resetn_o = outs_q.resetn;
    assign ctl.clkdiv_calib_o  = outs_q.calib;
    assign ctl.ready_o         = outs_q.ready;
    assign ctl.busy_o          = outs_q.busy;
    assign ctl.fail_o          = outs_q.fail;
    assign ctl.calib_cnt_o     = cnt_q;
endmodule

// File: tb/tb_clkdiv_seq_ctrl.sv
// tb_clkdiv_seq_ctrl: randomized scoreboard bench; expected output changes are timestamped and queued.
module tb_clkdiv_seq_ctrl;
    localparam int SYNC = 2, FILT = 8, HOLD = 16, SETTLE = 64, PW = 2, GAP = 8, MAXC = 4;
    localparam int BRING = SYNC + FILT + 1 + HOLD;
    localparam logic [4:0] V_OFF = 5'b00000, V_SETTLE = 5'b10000, V_READY = 5'b10100;
    localparam logic [4:0] V_PULSE = 5'b11010, V_GAP = 5'b10010, V_FAIL = 5'b10001;

    typedef struct {
        int         cyc;
        logic [7:0] v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         armed = 1'b0;
    int         m_cnt = 0;
    bit         m_fail = 1'b0;
    logic [7:0] prev = '0;
    exp_t       exp_q[$];

    clkdiv_seq_ctrl_if bus ();

    clkdiv_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] cur_vec();
        return {bus.clkdiv_resetn_o, bus.clkdiv_calib_o, bus.ready_o, bus.busy_o, bus.fail_o, bus.calib_cnt_o};
    endfunction

    function automatic void push(input int c, input logic [4:0] f, input int n);
        exp_t e;
        e.cyc = c;
        e.v   = {f, 3'(n)};
        exp_q.push_back(e);
    endfunction

    always @(negedge clk) begin
        logic [7:0] v;
        exp_t       e;
        v = cur_vec();
        if (armed && v !== prev) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_change cyc=%0d got=%b want=no change", cyc, v);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.v !== v) begin
                    bad++;
                    $display("FAIL out_change got=%b@%0d want=%b@%0d", v, cyc, e.v, e.cyc);
                end
            end
            prev = v;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic pulse_req(input bit aok);
        bus.calib_req_i = 1'b1;
        bus.align_ok_i  = aok;
        tick();
        bus.calib_req_i = 1'b0;
        bus.align_ok_i  = 1'b0;
    endtask

    // lock rises after a quiet spell, optionally preceded by a short glitch that must not count
    task automatic bring_up(input bit glitch);
        int l;
        bus.pll_lock_i = 1'b0;
        tick(4);
        if (glitch) begin
            bus.pll_lock_i = 1'b1;
            tick($urandom_range(FILT - 1, 1));
            bus.pll_lock_i = 1'b0;
            tick($urandom_range(3, 1));
        end
        bus.pll_lock_i = 1'b1;
        l = cyc;
        push(l + BRING, V_SETTLE, 0);
        push(l + BRING + SETTLE, V_READY, 0);
        wait_until(l + BRING + $urandom_range(SETTLE - 2, 0));
        pulse_req(1'b1);
        wait_until(l + BRING + SETTLE + 1);
        m_cnt = 0;
    endtask

    task automatic calib(input bit aok, input bit drop_in_gap);
        int r, n;
        r = cyc;
        n = aok ? 0 : m_cnt;
        if (n < MAXC) begin
            m_cnt = n + 1;
            push(r + 1, V_PULSE, m_cnt);
            push(r + 1 + PW, V_GAP, m_cnt);
            push(r + 1 + PW + GAP, V_READY, m_cnt);
        end else begin
            m_fail = 1'b1;
            push(r + 1, V_FAIL, n);
        end
        pulse_req(aok);
        if (n < MAXC) begin
            if (drop_in_gap) begin
                wait_until(r + PW + $urandom_range(GAP - 1, 1));
                pulse_req(1'b1);
            end
            wait_until(r + 1 + PW + GAP + $urandom_range(9, 0));
        end else begin
            tick(3);
        end
    endtask

    task automatic align_only();
        if (m_cnt != 0) push(cyc + 1, V_READY, 0);
        m_cnt = 0;
        bus.align_ok_i = 1'b1;
        tick();
        bus.align_ok_i = 1'b0;
        tick(2);
    endtask

    task automatic en_cycle();
        int e;
        bus.enable_i = 1'b0;
        push(cyc + 1, V_OFF, 0);
        tick(1 + $urandom_range(3, 0));
        bus.enable_i = 1'b1;
        e = cyc;
        m_cnt  = 0;
        m_fail = 1'b0;
        push(e + 2 + HOLD, V_SETTLE, 0);
        push(e + 2 + HOLD + SETTLE, V_READY, 0);
        wait_until(e + 2 + HOLD + SETTLE + 1);
    endtask

    // lock drops d cycles after a request (d=-1: one cycle before), truncating the pulse/gap
    task automatic lock_loss(input int d);
        int a, r;
        if (d < 0) begin
            bus.pll_lock_i = 1'b0;
            tick();
        end
        r = cyc;
        a = r + d;
        m_cnt = 1;
        push(r + 1, V_PULSE, 1);
        if (d > 0) push(r + 1 + PW, V_GAP, 1);
        push(a + SYNC + 1, V_OFF, 0);
        if (d == 0) bus.pll_lock_i = 1'b0;
        pulse_req(1'b1);
        if (d > 0) begin
            wait_until(a);
            bus.pll_lock_i = 1'b0;
        end
        wait_until(a + SYNC + 2);
        m_cnt = 0;
    endtask

    task automatic mid_reset();
        int l;
        rst = 1'b1;
        push(cyc, V_OFF, 0);
        m_cnt  = 0;
        m_fail = 1'b0;
        tick(2);
        rst = 1'b0;
        l = cyc;
        push(l + BRING, V_SETTLE, 0);
        push(l + BRING + SETTLE, V_READY, 0);
        wait_until(l + BRING + SETTLE + 1);
    endtask

    initial begin
        bus.enable_i    = 1'b0;
        bus.pll_lock_i  = 1'b0;
        bus.calib_req_i = 1'b0;
        bus.align_ok_i  = 1'b0;
        tick(3);
        chk("reset_outputs", int'(cur_vec()), 0);
        rst   = 1'b0;
        armed = 1'b1;
        bus.enable_i = 1'b1;
        bring_up(1'b0);
        repeat (3) calib(1'b0, 1'(($urandom_range(1, 0))));
        chk("calib_cnt_after_3", int'(bus.calib_cnt_o), 3);
        align_only();
        chk("calib_cnt_after_align", int'(bus.calib_cnt_o), 0);
        repeat (5) calib(1'b0, 1'b0);
        chk("fail_flag", int'(bus.fail_o), 1);
        chk("ready_in_fail", int'(bus.ready_o), 0);
        pulse_req(1'b0);
        tick(3);
        en_cycle();
        chk("fail_cleared", int'(bus.fail_o), 0);
        lock_loss(1);
        bring_up(1'b1);
        repeat (12) begin
            case ($urandom_range(5, 0))
                0, 1: calib(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
                2: align_only();
                3: begin
                    lock_loss($urandom_range(8, 0) - 1);
                    bring_up(1'($urandom_range(1, 0)));
                end
                4: en_cycle();
                default: mid_reset();
            endcase
            if (m_fail) en_cycle();
        end
        tick(20);
        chk("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
